// File: rtl/instr_encoder.sv
// Instruction encoder: packs register fields and a sign-extended immediate into
// I/S/B/U/J words, and expands the LI pseudo-op into ADDI, LUI or LUI+ADDI.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        out_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FINAL = 2'd1,
    HI    = 2'd2
  } state_t;

  state_t      state_r, state_n_s;
  logic [31:0] instr_r, instr_n_s;
  logic        last_r, last_n_s;
  logic        err_r, err_n_s;
  logic [31:0] pend_r, pend_n_s;

  logic [31:0] enc_word_s;
  logic        enc_err_s;
  logic        enc_two_s;
  logic [31:0] addi_word_s;
  logic [19:0] hi_s;
  logic        fits12_s;

  // True when bits 31..11 are a pure sign extension (value fits a 12-bit signed field)
  function automatic logic sext_ok(input logic [31:0] v, input int unsigned msb_keep);
    logic [31:0] top;
    top = v >> msb_keep;
    return (top == 32'd0) || (top == (32'hFFFF_FFFF >> msb_keep));
  endfunction

  // Combinational encoder for the request currently on the input port
  always_comb begin
    enc_word_s  = 32'h0000_0000;
    enc_err_s   = 1'b0;
    enc_two_s   = 1'b0;
    fits12_s    = sext_ok(imm, 32'd11);
    // ADDI upper-half correction: a negative low half borrows one from the LUI part
    hi_s        = imm[31:12] + {19'd0, imm[11]};
    addi_word_s = {imm[11:0], rd, 3'b000, rd, 7'b0010011};
    case (fmt)
      3'b000: begin
        enc_word_s = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err_s  = !fits12_s;
      end
      3'b001: begin
        enc_word_s = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err_s  = !fits12_s;
      end
      3'b010: begin
        enc_word_s = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err_s  = imm[0] || !sext_ok(imm, 32'd12);
      end
      3'b011: begin
        enc_word_s = {imm[31:12], rd, opcode};
        enc_err_s  = (imm[11:0] != 12'd0);
      end
      3'b100: begin
        enc_word_s = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err_s  = imm[0] || !sext_ok(imm, 32'd20);
      end
      3'b101: begin
        if (fits12_s) begin
          enc_word_s = {imm[11:0], 5'd0, 3'b000, rd, 7'b0010011};
          enc_two_s  = 1'b0;
        end else begin
          enc_word_s = {hi_s, rd, 7'b0110111};
          enc_two_s  = (imm[11:0] != 12'd0);
        end
      end
      default: begin
        enc_word_s = 32'h0000_0013;
        enc_err_s  = 1'b1;
      end
    endcase
  end

  assign in_ready  = (state_r == IDLE) || ((state_r == FINAL) && out_ready);
  assign out_valid = (state_r != IDLE);
  assign out_instr = instr_r;
  assign out_last  = last_r;
  assign out_err   = err_r;

  // Next-state and output-word selection
  always_comb begin
    state_n_s = state_r;
    instr_n_s = instr_r;
    last_n_s  = last_r;
    err_n_s   = err_r;
    pend_n_s  = pend_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_n_s = enc_two_s ? HI : FINAL;
          instr_n_s = enc_word_s;
          last_n_s  = !enc_two_s;
          err_n_s   = enc_err_s;
          pend_n_s  = addi_word_s;
        end else begin
          state_n_s = IDLE;
        end
      end
      HI: begin
        if (out_ready) begin
          state_n_s = FINAL;
          instr_n_s = pend_r;
          last_n_s  = 1'b1;
          err_n_s   = 1'b0;
        end else begin
          state_n_s = HI;
        end
      end
      FINAL: begin
        if (out_ready && in_valid) begin
          state_n_s = enc_two_s ? HI : FINAL;
          instr_n_s = enc_word_s;
          last_n_s  = !enc_two_s;
          err_n_s   = enc_err_s;
          pend_n_s  = addi_word_s;
        end else if (out_ready) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = FINAL;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      instr_r <= 32'h0000_0000;
      last_r  <= 1'b0;
      err_r   <= 1'b0;
      pend_r  <= 32'h0000_0000;
    end else begin
      state_r <= state_n_s;
      instr_r <= instr_n_s;
      last_r  <= last_n_s;
      err_r   <= err_n_s;
      pend_r  <= pend_n_s;
    end
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high: clk, reset.
REQ-002 Ports SHALL be as follows:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid && in_ready at a clk edge
- fmt  in  3  000 I, 001 S, 010 B, 011 U, 100 J, 101 LI pseudo-op; 110/111 reserved
- opcode  in  7  opcode field; ignored for LI
- funct3  in  3  funct3 field; ignored for U, J and LI
- rd, rs1, rs2  in  5 each  register fields
- imm  in  32  full sign-extended immediate value, the same value the immediate extender produces on decode
- out_valid  out  1  encoded word present
- out_ready  in  1  consumer takes the word when out_valid && out_ready
- out_instr  out  32  encoded instruction
- out_last  out  1  final word of the current request
- out_err  out  1  immediate not representable in the chosen format

Function
REQ-003 Encoding per fmt (bit concatenation, MSB first):
- I: {imm[11:0], rs1, funct3, rd, opcode}
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
- B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
- U: {imm[31:12], rd, opcode}
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
REQ-004 out_err conditions: I/S if imm[31:11] not all equal; B if imm[0]=1 or imm[31:12] not all equal; U if imm[11:0]!=0; J if imm[0]=1 or imm[31:20] not all equal. On error the word is still emitted, with truncated fields.
REQ-005 LI, when imm[31:11] are all equal: one word ADDI {imm[11:0], 5'd0, 3'b000, rd, 7'b0010011}, out_last=1.
REQ-006 LI otherwise: hi = imm[31:12] + imm[11] (20-bit, wraps modulo 2^20).
- Emit LUI {hi, rd, 7'b0110111} first.
- If imm[11:0]!=0, then emit ADDI {imm[11:0], rd, 3'b000, rd, 7'b0010011}.
- out_last=1 only on the final word.
- out_err is always 0 for LI.
REQ-007 Reserved fmt SHALL emit one word 32'h00000013 with out_err=1, out_last=1.
REQ-008 The FSM SHALL have states IDLE, FINAL (holding the last word) and HI (holding LUI, ADDI pending).
- IDLE -> FINAL on accept of a single-word request.
- IDLE -> HI on accept of a two-word LI.
- HI -> FINAL on an out handshake, loading ADDI.
- FINAL -> IDLE on an out handshake with no new accept.
- FINAL -> FINAL/HI on an out handshake with a simultaneous accept.
REQ-009 in_ready = (state==IDLE) || (state==FINAL && out_ready); in_ready SHALL be low in HI.
REQ-010 Latency: a request accepted at edge N SHALL present its first word with out_valid=1 after edge N. Back-to-back single-word requests SHALL sustain 1 word/cycle.
REQ-011 While out_valid && !out_ready, out_instr, out_last and out_err SHALL hold stable.
REQ-012 out_valid SHALL be 1 exactly in FINAL and HI.
REQ-013 Decoding any emitted non-error word with the codebase immediate extender SHALL reproduce imm. For two-word LI, (hi<<12) + sext(imm[11:0]) SHALL equal imm modulo 2^32.

Reset
REQ-014 Reset SHALL force, at the next edge: state=IDLE, out_valid=0, out_instr=0, out_last=0, out_err=0.
REQ-015 Reset SHALL take priority over in_valid. A pending ADDI is discarded, and no request is accepted in the reset cycle.
REQ-016 in_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-017 I-type: fmt=000, opcode=0010011, funct3=000, rd=5, rs1=6, imm=32'hFFFFFFFF -> out_instr=32'hFFF30293, out_last=1, out_err=0, one cycle after accept.
REQ-018 LI two-word: fmt=101, rd=10, imm=32'h12345FFF, out_ready=1 -> 32'h12346537 (out_last=0), then 32'hFFF50513 (out_last=1); in_ready=0 during the first word.
REQ-019 B-type: opcode=1100011, funct3=000, rs1=1, rs2=2, imm=8 -> 32'h00208463, out_err=0. Same with imm=9 -> out_err=1.
REQ-020 LI LUI-only: rd=1, imm=32'h00001000 -> single word 32'h000010B7, out_last=1.
REQ-021 Backpressure: hold out_ready=0 for 3 cycles on the REQ-017 word -> out_instr stable, in_ready=0; then release with a new in_valid -> back-to-back words, no gap.
REQ-022 Reset mid-LI: assert reset while LUI (REQ-018) is held -> out_valid=0 next cycle, ADDI never emitted, in_ready=1 after release.
